// File: rtl/imm_pkg.sv
// imm_pkg
// Shared constants for the immediate-generation stage:
//   fmt_e      - format codes reported on the stage's fmt output
//   OP_*       - opcode match constants, each sized to the instruction
//                bits it is compared against (top bits of the word)
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_I    = 3'd3,
        FMT_B    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_e;

    // D format, compared against instr[31:21]
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CB format, compared against instr[31:24]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    // I format, compared against instr[31:22]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    // B format, compared against instr[31:26]
    localparam logic [5:0]  OP_B    = 6'b000101;
    // IW format, compared against instr[31:23]
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
// Purely combinational format match and immediate extension.
// Parameters:
//   N        - immediate width (N >= 32)
//   BR_SHIFT - when 1, CB and B immediates are shifted left by 2 after
//              extension, truncated to N bits
// Ports:
//   instr - instruction word
//   imm   - extended immediate (0 when nothing matches)
//   fmt   - format code (FMT_NONE when nothing matches)
//   hit   - 1 when instr matched a known format
module imm_decode
    import imm_pkg::*;
#(
    parameter int N        = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic [31:0]  instr,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt,
    output logic         hit
);

    logic [N-1:0] ext_d;
    logic [N-1:0] ext_cb;
    logic [N-1:0] ext_i;
    logic [N-1:0] ext_b;
    logic [N-1:0] ext_iw;
    logic [N-1:0] imm_cb;
    logic [N-1:0] imm_b;
    logic [5:0]   iw_shamt;
    fmt_e         fmt_sel;

    assign ext_d  = {{(N-9){instr[20]}},  instr[20:12]};
    assign ext_cb = {{(N-19){instr[23]}}, instr[23:5]};
    assign ext_i  = {{(N-12){1'b0}},      instr[21:10]};
    assign ext_b  = {{(N-26){instr[25]}}, instr[25:0]};

    // MOVZ: hw selects a 16-bit lane; lanes at or above N simply shift
    // out, which is how bits beyond N get dropped.
    assign iw_shamt = {instr[22:21], 4'b0000};
    assign ext_iw   = {{(N-16){1'b0}}, instr[20:5]} << iw_shamt;

    assign imm_cb = (BR_SHIFT == 1) ? (ext_cb << 2) : ext_cb;
    assign imm_b  = (BR_SHIFT == 1) ? (ext_b  << 2) : ext_b;

    always_comb begin
        imm     = '0;
        fmt_sel = FMT_NONE;
        hit     = 1'b0;
        if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            imm     = ext_d;
            fmt_sel = FMT_D;
            hit     = 1'b1;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
            imm     = imm_cb;
            fmt_sel = FMT_CB;
            hit     = 1'b1;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
            imm     = ext_i;
            fmt_sel = FMT_I;
            hit     = 1'b1;
        end else if (instr[31:26] == OP_B) begin
            imm     = imm_b;
            fmt_sel = FMT_B;
            hit     = 1'b1;
        end else if (instr[31:23] == OP_MOVZ) begin
            imm     = ext_iw;
            fmt_sel = FMT_IW;
            hit     = 1'b1;
        end
    end

    assign fmt = fmt_sel;

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
// One pipeline stage that decodes an instruction's immediate and buffers
// it behind a registered output plus a one-entry skid register.
// Parameters:
//   N        - immediate width (N >= 32)
//   BR_SHIFT - when 1, CB and B immediates are shifted left by 2
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   instr, in_valid     - instruction offered by the producer
//   in_ready            - registered "skid empty"
//   flush               - drop held entries and any same-cycle input
//   imm, fmt, hit       - output payload
//   out_valid/out_ready - output handshake
//   miss_cnt            - saturating count of accepted unmatched instrs
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer may not withdraw or change a valid entry until
// it transfers; this stage holds imm/fmt/hit stable while out_valid is
// high and out_ready is low. flush blocks the input transfer but not the
// output transfer in the same cycle.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int N        = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  instr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt,
    output logic         hit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  miss_cnt
);

    logic [N-1:0] dec_imm;
    logic [2:0]   dec_fmt;
    logic         dec_hit;

    logic [N-1:0] skid_imm;
    logic [2:0]   skid_fmt;
    logic         skid_hit;
    logic         skid_valid;

    logic         accept;
    logic         drain;
    logic         out_free;

    imm_decode #(
        .N        (N),
        .BR_SHIFT (BR_SHIFT)
    ) u_decode (
        .instr (instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt),
        .hit   (dec_hit)
    );

    assign accept   = in_valid && in_ready && !flush;
    assign drain    = out_valid && out_ready;
    // Output register can take a new entry at this edge.
    assign out_free = !out_valid || drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            imm        <= '0;
            fmt        <= FMT_NONE;
            hit        <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
            skid_hit   <= 1'b0;
            in_ready   <= 1'b1;
            miss_cnt   <= '0;
        end else if (flush) begin
            // Any drain this cycle has already been seen by the consumer;
            // clearing out_valid finishes it and drops everything held.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    // in_ready was low, so no accept can collide here.
                    out_valid  <= 1'b1;
                    imm        <= skid_imm;
                    fmt        <= skid_fmt;
                    hit        <= skid_hit;
                    skid_valid <= 1'b0;
                    in_ready   <= 1'b1;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    imm       <= dec_imm;
                    fmt       <= dec_fmt;
                    hit       <= dec_hit;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                // Output stalled: park the new entry in the skid register.
                skid_valid <= 1'b1;
                skid_imm   <= dec_imm;
                skid_fmt   <= dec_fmt;
                skid_hit   <= dec_hit;
                in_ready   <= 1'b0;
            end

            if (accept && !dec_hit && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage
// Directed bench for imm_gen_stage. Three instances share one set of
// inputs: N=64/BR_SHIFT=0 (main), N=64/BR_SHIFT=1 and N=32/BR_SHIFT=0.
module tb_imm_gen_stage;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        hit;
    logic        out_valid;
    logic [15:0] miss_cnt;

    logic        in_ready_br;
    logic [63:0] imm_br;
    logic [2:0]  fmt_br;
    logic        hit_br;
    logic        out_valid_br;
    logic [15:0] miss_cnt_br;

    logic        in_ready_32;
    logic [31:0] imm_32;
    logic [2:0]  fmt_32;
    logic        hit_32;
    logic        out_valid_32;
    logic [15:0] miss_cnt_32;

    int n_checks;
    int n_errors;

    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    imm_gen_stage #(.N(64), .BR_SHIFT(0)) dut (
        .clk (clk), .reset (reset), .instr (instr), .in_valid (in_valid),
        .in_ready (in_ready), .flush (flush), .imm (imm), .fmt (fmt),
        .hit (hit), .out_valid (out_valid), .out_ready (out_ready),
        .miss_cnt (miss_cnt)
    );

    imm_gen_stage #(.N(64), .BR_SHIFT(1)) dut_br (
        .clk (clk), .reset (reset), .instr (instr), .in_valid (in_valid),
        .in_ready (in_ready_br), .flush (flush), .imm (imm_br), .fmt (fmt_br),
        .hit (hit_br), .out_valid (out_valid_br), .out_ready (out_ready),
        .miss_cnt (miss_cnt_br)
    );

    imm_gen_stage #(.N(32), .BR_SHIFT(0)) dut_32 (
        .clk (clk), .reset (reset), .instr (instr), .in_valid (in_valid),
        .in_ready (in_ready_32), .flush (flush), .imm (imm_32), .fmt (fmt_32),
        .hit (hit_32), .out_valid (out_valid_32), .out_ready (out_ready),
        .miss_cnt (miss_cnt_32)
    );

    // ---------------- driver tasks ----------------
    // Advance one cycle; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    logic [31:0] v_instr  [10];
    logic [63:0] v_imm    [10];
    logic [63:0] v_imm_br [10];
    logic [31:0] v_imm_32 [10];
    logic [2:0]  v_fmt    [10];

    initial begin
        //            LDUR          STUR          CBZ           CBNZ
        //            ADDI          SUBI          B             MOVZ hw3
        //            MOVZ hw1      none
        v_instr  = '{32'hF85F8000, 32'hF80FF000, 32'hB4FFFFE0, 32'hB5000020,
                     32'h913FFC00, 32'hD1200000, 32'h16000000, 32'hD2F579A0,
                     32'hD2B579A0, 32'h00000000};
        v_imm    = '{64'hFFFFFFFFFFFFFFF8, 64'h00000000000000FF,
                     64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001,
                     64'h0000000000000FFF, 64'h0000000000000800,
                     64'hFFFFFFFFFE000000, 64'hABCD000000000000,
                     64'h00000000ABCD0000, 64'h0000000000000000};
        v_imm_br = '{64'hFFFFFFFFFFFFFFF8, 64'h00000000000000FF,
                     64'hFFFFFFFFFFFFFFFC, 64'h0000000000000004,
                     64'h0000000000000FFF, 64'h0000000000000800,
                     64'hFFFFFFFFF8000000, 64'hABCD000000000000,
                     64'h00000000ABCD0000, 64'h0000000000000000};
        v_imm_32 = '{32'hFFFFFFF8, 32'h000000FF, 32'hFFFFFFFF, 32'h00000001,
                     32'h00000FFF, 32'h00000800, 32'hFE000000, 32'h00000000,
                     32'hABCD0000, 32'h00000000};
        v_fmt    = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd0};
    end

    // ---------------- main sequence ----------------
    initial begin
        int n_out;
        int n_bad;
        logic take;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        instr     = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_imm",       imm,            64'd0);
        check("rst_fmt",       64'(fmt),       64'd0);
        check("rst_hit",       64'(hit),       64'd0);
        check("rst_miss_cnt",  64'(miss_cnt),  64'd0);

        // decode table, one instruction at a time with out_ready high
        for (int i = 0; i < 10; i++) begin
            instr    = v_instr[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("dec%0d_valid", i),  64'(out_valid), 64'd1);
            check($sformatf("dec%0d_imm", i),    imm,            v_imm[i]);
            check($sformatf("dec%0d_fmt", i),    64'(fmt),       64'(v_fmt[i]));
            check($sformatf("dec%0d_hit", i),    64'(hit),       64'(v_fmt[i] != 3'd0));
            check($sformatf("dec%0d_imm_br", i), imm_br,         v_imm_br[i]);
            check($sformatf("dec%0d_imm_32", i), 64'(imm_32),    64'(v_imm_32[i]));
            step();
            check($sformatf("dec%0d_drained", i), 64'(out_valid), 64'd0);
        end
        check("dec_miss_cnt", 64'(miss_cnt), 64'd1);

        // stall: A held, B in skid, C refused, then A,B,C in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hF80FF000;                     // A: imm 0xFF
        exp_q.push_back(64'h00000000000000FF);
        step();
        check("stall_in_ready_a", 64'(in_ready), 64'd1);
        instr = 32'h913FFC00;                         // B: imm 0xFFF
        exp_q.push_back(64'h0000000000000FFF);
        step();
        check("stall_in_ready_b", 64'(in_ready), 64'd0);
        instr = 32'hB5000020;                         // C: imm 1
        exp_q.push_back(64'h0000000000000001);
        step();
        check("stall_hold_imm",   imm,              64'h00000000000000FF);
        check("stall_hold_fmt",   64'(fmt),         64'd1);
        check("stall_in_ready_c", 64'(in_ready),    64'd0);
        check("stall_out_valid",  64'(out_valid),   64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stall_extra_out", imm, 64'hDEAD);
                end else begin
                    check($sformatf("stall_order%0d", i), imm, exp_q.pop_front());
                end
            end
            take = in_valid && in_ready;
            step();
            if (take) in_valid = 1'b0;
        end
        check("stall_q_empty", 64'(exp_q.size()), 64'd0);
        check("stall_idle",    64'(out_valid),    64'd0);

        // flush with output and skid full (both unmatched, miss 1 -> 3)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00000000;
        step();
        step();
        check("flush_pre_in_ready", 64'(in_ready), 64'd0);
        check("flush_pre_miss",     64'(miss_cnt), 64'd3);
        flush = 1'b1;
        step();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        check("flush_miss",      64'(miss_cnt),  64'd3);
        // in_ready is now high: a same-cycle input must still be dropped
        step();
        check("flush_drop_valid", 64'(out_valid), 64'd0);
        check("flush_drop_miss",  64'(miss_cnt),  64'd3);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("flush_no_extra", 64'(out_valid), 64'd0);

        // reset mid-stall with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hF85F8000;
        step();
        step();
        check("rst2_pre_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready",  64'(in_ready),  64'd1);
        check("rst2_miss",      64'(miss_cnt),  64'd0);
        check("rst2_imm",       imm,            64'd0);
        out_ready = 1'b1;
        step();
        check("rst2_no_stale", 64'(out_valid), 64'd0);

        // miss_cnt saturation: 0x10000 unmatched instructions
        n_out    = 0;
        n_bad    = 0;
        instr    = 32'h00000000;
        in_valid = 1'b1;
        for (int k = 1; k <= 65536; k++) begin
            step();
            if (out_valid) begin
                n_out++;
                if (imm !== 64'd0 || fmt !== 3'd0 || hit !== 1'b0) n_bad++;
            end
            if (k == 65534) check("sat_miss_fffe", 64'(miss_cnt), 64'hFFFE);
            if (k == 65535) check("sat_miss_ffff", 64'(miss_cnt), 64'hFFFF);
        end
        in_valid = 1'b0;
        check("sat_miss_hold", 64'(miss_cnt), 64'hFFFF);
        step();
        check("sat_out_count", 64'(n_out),     64'd65536);
        check("sat_out_zero",  64'(n_bad),     64'd0);
        check("sat_idle",      64'(out_valid), 64'd0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
